// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Contents: register indices, controller state enum, per-event stall/flush patterns.
// Patterns use bit order IF/ID=0, ID/EX=1, EX/MEM=2, MEM/WB=3.
package pipe_ctrl_pkg;

  localparam int REG_IF_ID  = 0;
  localparam int REG_ID_EX  = 1;
  localparam int REG_EX_MEM = 2;
  localparam int REG_MEM_WB = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } pipe_ctrl_state_t;

  // Memory wait: freeze IF..EX, drop a bubble into MEM/WB.
  localparam logic [3:0] MEM_STALL = 4'b0111;
  localparam logic [3:0] MEM_FLUSH = 4'b1 << REG_MEM_WB;
  // Divide: hold IF/ID and ID/EX, bubble into EX/MEM while EX is busy.
  localparam logic [3:0] DIV_STALL = 4'b0011;
  localparam logic [3:0] DIV_FLUSH = 4'b1 << REG_EX_MEM;
  // Taken branch: kill the two wrong-path instructions younger than EX.
  localparam logic [3:0] BR_FLUSH  = 4'b0011;
  // Load-use: hold the consumer in ID, bubble into EX.
  localparam logic [3:0] LU_STALL  = 4'b1 << REG_IF_ID;
  localparam logic [3:0] LU_FLUSH  = 4'b1 << REG_ID_EX;
  // Exception: clear the whole pipeline.
  localparam logic [3:0] EXC_FLUSH = 4'b1111;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use hazard compare between the load in EX and the sources read by ID.
// Ports: i_id_rs1/i_id_rs2 + use flags, i_ex_is_load, i_ex_rd -> o_hazard.
// Purely combinational; x0 never creates a hazard.
module load_use_detect (
  input  logic       i_ex_is_load,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  output logic       o_hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_hazard  = i_ex_is_load && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: exception > mem wait > divide > branch > load-use.
// Ports: hazard sources from ID/EX/MEM in; pc_stall, stall[3:0], flush[3:0], div_done, stall_cnt out.
// Outputs are Mealy so the pipeline registers react in the same cycle; forced to 0 while rst is low.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic             ex_div,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             exc_valid,
  output logic             pc_stall,
  output logic [3:0]       stall,
  output logic [3:0]       flush,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DCW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  // The start cycle is the first stalled cycle, so the counter covers DIV_LAT-2 more.
  localparam logic [DCW-1:0] DIV_RELOAD = DCW'(DIV_LAT - 2);

  pipe_ctrl_state_t r_state;
  pipe_ctrl_state_t w_next_state;
  logic [DCW-1:0]   r_div_cnt;
  logic [DCW-1:0]   w_next_div_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_hazard;
  logic             w_pc_stall;
  logic [3:0]       w_stall;
  logic [3:0]       w_flush;
  logic             w_div_done;

  load_use_detect u_load_use (
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_use_rs2 (id_use_rs2),
    .o_hazard     (w_hazard)
  );

  always_comb begin
    w_next_state   = r_state;
    w_next_div_cnt = r_div_cnt;
    w_pc_stall     = 1'b0;
    w_stall        = 4'b0000;
    w_flush        = 4'b0000;
    w_div_done     = 1'b0;

    if (exc_valid) begin
      w_flush        = EXC_FLUSH;
      w_next_state   = RUN;
      w_next_div_cnt = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (mem_req && !mem_ack) begin
            w_pc_stall   = 1'b1;
            w_stall      = MEM_STALL;
            w_flush      = MEM_FLUSH;
            w_next_state = MEM_WAIT;
          end else if (ex_div) begin
            w_pc_stall     = 1'b1;
            w_stall        = DIV_STALL;
            w_flush        = DIV_FLUSH;
            w_next_div_cnt = DIV_RELOAD;
            w_next_state   = DIV_WAIT;
          end else if (ex_br_taken) begin
            w_flush = BR_FLUSH;
          end else if (w_hazard) begin
            w_pc_stall = 1'b1;
            w_stall    = LU_STALL;
            w_flush    = LU_FLUSH;
          end
        end
        MEM_WAIT: begin
          // The wait is held by the missing ack alone; mem_req need not stay high.
          if (!mem_ack) begin
            w_pc_stall = 1'b1;
            w_stall    = MEM_STALL;
            w_flush    = MEM_FLUSH;
          end else if (ex_div) begin
            // A divide that queued behind the access starts on the release cycle.
            w_pc_stall     = 1'b1;
            w_stall        = DIV_STALL;
            w_flush        = DIV_FLUSH;
            w_next_div_cnt = DIV_RELOAD;
            w_next_state   = DIV_WAIT;
          end else begin
            w_next_state = RUN;
          end
        end
        DIV_WAIT: begin
          if (mem_req && !mem_ack) begin
            // Older access in MEM: hold EX/MEM too and pause the divide count.
            w_pc_stall = 1'b1;
            w_stall    = MEM_STALL;
            w_flush    = MEM_FLUSH;
          end else if (r_div_cnt != '0) begin
            w_pc_stall     = 1'b1;
            w_stall        = DIV_STALL;
            w_flush        = DIV_FLUSH;
            w_next_div_cnt = r_div_cnt - 1'b1;
          end else begin
            w_div_done   = 1'b1;
            w_next_state = RUN;
          end
        end
        default: begin
          w_next_state   = RUN;
          w_next_div_cnt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_div_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_div_cnt <= w_next_div_cnt;
      if (w_pc_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_stall  = rst & w_pc_stall;
  assign stall     = {4{rst}} & w_stall;
  assign flush     = {4{rst}} & w_flush;
  assign div_done  = rst & w_div_done;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage in-order pipeline. It drives the stall and flush inputs of the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC stall. It resolves load-use hazards, taken-branch redirects, multi-cycle divide occupancy, memory wait states and exceptions under one fixed priority. Outputs are Mealy (state + inputs) so the registers see them in the same cycle.

Parameters:
DIV_LAT, 8, divider occupancy in cycles (>=2); EX is held for exactly DIV_LAT cycles
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
id_rs1  in  5  source register 1 of the instruction in ID
id_rs2  in  5  source register 2 of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_is_load  in  1  EX instruction is a load
ex_rd  in  5  destination register of the EX instruction
ex_br_taken  in  1  EX resolved a taken branch/jump (redirect)
ex_div  in  1  EX holds a divide; stays high while the divide sits in EX
mem_req  in  1  MEM stage issues a data access this cycle
mem_ack  in  1  data memory completes the access this cycle
exc_valid  in  1  exception raised by the instruction in MEM
pc_stall  out  1  hold PC
stall  out  4  per-register stall, bit0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB
flush  out  4  per-register flush, same bit order (flush beats stall inside the register)
div_done  out  1  one-cycle pulse: divide result valid, EX/MEM captures it
stall_cnt  out  CNT_W  count of cycles with pc_stall=1, wraps modulo 2^CNT_W

Behaviour:
- State: RUN, MEM_WAIT, DIV_WAIT. Counter div_cnt sized clog2(DIV_LAT).
- Reset (rst low, asynchronous): state=RUN, div_cnt=0, stall_cnt=0. While rst is low, pc_stall, stall, flush and div_done are all 0.
- Default (no event): all outputs 0.
- Evaluation priority per cycle: exception > memory wait > divide > branch > load-use.
- Exception (any state): exc_valid=1 -> flush=4'b1111, stall=0, pc_stall=0. Next state is RUN and div_cnt=0.
- Memory wait:
  - In RUN, mem_req=1 with mem_ack=0 -> pc_stall=1, stall=4'b0111, flush=4'b1000. Next state is MEM_WAIT.
  - In MEM_WAIT with mem_ack=0 -> same pattern.
  - In MEM_WAIT with mem_ack=1 -> release: no stall, next state RUN. If ex_div=1 in the release cycle, apply the divide-start pattern instead and go to DIV_WAIT.
  - mem_req and mem_ack high in the same RUN cycle -> no stall.
- Divide:
  - In RUN, ex_div=1 with no memory wait -> pc_stall=1, stall=4'b0011, flush=4'b0100. Load div_cnt=DIV_LAT-2 and go to DIV_WAIT.
  - In DIV_WAIT with div_cnt!=0 -> same pattern, decrement div_cnt.
  - In DIV_WAIT with div_cnt==0 -> release cycle: div_done=1, no stall or flush, next state RUN.
  - Total cycles with pc_stall=1 = DIV_LAT-1; EX occupancy = DIV_LAT including the release cycle.
  - ex_div is ignored in the release cycle and in MEM_WAIT (except the release transition above).
  - A memory wait arising during DIV_WAIT (older instruction in MEM) -> apply the memory-wait pattern (EX/MEM is held, not flushed), freeze div_cnt and stay in DIV_WAIT.
- Branch: only in RUN with no higher event. ex_br_taken=1 -> flush=4'b0011, no stall. A branch while stalled is ignored; it re-presents on release.
- Load-use: only in RUN with no higher event and ex_br_taken=0. Hazard when ex_is_load=1, ex_rd!=0, and either (id_use_rs1 && id_rs1==ex_rd) or (id_use_rs2 && id_rs2==ex_rd). Response: pc_stall=1, stall=4'b0001, flush=4'b0010. Lasts one cycle, no state change.
- stall_cnt increments on every cycle with pc_stall=1.

Decomposition:
- Package pipe_ctrl_pkg:
  - register index constants REG_IF_ID=0, REG_ID_EX=1, REG_EX_MEM=2, REG_MEM_WB=3
  - state enum pipe_ctrl_state_t {RUN, MEM_WAIT, DIV_WAIT}
  - pattern constants for each event's stall/flush vectors
- Sub-module: load_use_detect (combinational hazard compare), instantiated once.

Test Plan:
1. Load x5 in EX, ID reads rs2=x5 -> one cycle pc_stall=1, stall=0001, flush=0010; next cycle all 0. Repeat with ex_rd=0 -> no stall.
2. DIV_LAT=8, ex_div held high from cycle 0 -> pc_stall=1 for cycles 0..6, div_done=1 at cycle 7, stall_cnt=7.
3. mem_req=1, mem_ack low for 3 cycles then high -> stall=0111, flush=1000 for 3 cycles; release on the ack cycle with all 0.
4. ex_br_taken=1 together with a load-use hazard in RUN -> flush=0011, pc_stall=0.
5. exc_valid=1 mid-DIV_WAIT (div_cnt=3) -> flush=1111 that cycle; next cycle state RUN, div_done never pulses.
6. Assert rst low mid-MEM_WAIT -> outputs 0 immediately; after release, state RUN and stall_cnt=0.
